// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among NREQ packet requesters.
// Optional stall release of a silent owner is built when UART_ARB_TIMEOUT_EN is defined.

module uart_tx_arb_lane (
  input  logic       own,
  input  logic       locked,
  input  logic       tx_txe,
  input  logic [7:0] data,
  output logic       ready,
  output logic [7:0] sel_data
);
  assign ready    = own & locked & tx_txe;
  assign sel_data = data & {8{own}};
endmodule

module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_txe,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              timeout
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, LOCKED, ISSUE} state_t;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: NREQ must be 2..8 and TIMEOUT >= 1");
  end

  state_t                 state, state_d;
  logic [IW-1:0]          rr_ptr, rr_d, owner, owner_d, pick;
  logic [NREQ-1:0]        grant_d;
  logic                   busy_d, start_d, last_q, last_d, locked, own_last, xfer;
  logic [7:0]             data_d, own_data;
  logic [NREQ-1:0][7:0]   lane_data;

  assign locked = (state == LOCKED);

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    uart_tx_arb_lane u_lane (
      .own      (grant[i]),
      .locked   (locked),
      .tx_txe   (tx_txe),
      .data     (req_data[8*i +: 8]),
      .ready    (req_ready[i]),
      .sel_data (lane_data[i])
    );
  end

  always_comb begin
    own_data = '0;
    for (int i = 0; i < NREQ; i++) own_data |= lane_data[i];
  end

  assign own_last = |(req_last & grant);
  assign xfer     = |(req_valid & req_ready);

  // Walk from the farthest slot back toward rr_ptr+1 so the nearest valid requester wins.
  always_comb begin
    pick = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NREQ]) pick = IW'((int'(rr_ptr) + k) % NREQ);
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] stall, stall_d;
  logic          timeout_d, own_valid;
  assign own_valid = |(req_valid & grant);
`endif

  always_comb begin
    state_d = state;
    rr_d    = rr_ptr;
    owner_d = owner;
    grant_d = grant;
    busy_d  = busy;
    start_d = 1'b0;
    data_d  = tx_data;
    last_d  = last_q;
`ifdef UART_ARB_TIMEOUT_EN
    stall_d   = '0;
    timeout_d = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (|req_valid) begin
          owner_d = pick;
          grant_d = '0;
          grant_d[pick] = 1'b1;
          busy_d  = 1'b1;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (xfer) begin
          start_d = 1'b1;
          data_d  = own_data;
          last_d  = own_last;
          state_d = ISSUE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (!own_valid) begin
          if (stall == CW'(TIMEOUT - 1)) begin
            rr_d      = owner;
            grant_d   = '0;
            busy_d    = 1'b0;
            timeout_d = 1'b1;
            state_d   = IDLE;
          end else begin
            stall_d = stall + CW'(1);
          end
        end
`endif
      end
      ISSUE: begin
        if (last_q) begin
          rr_d    = owner;
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = LOCKED;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      rr_ptr   <= IW'(NREQ - 1);
      owner    <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      last_q   <= 1'b0;
    end else begin
      state    <= state_d;
      rr_ptr   <= rr_d;
      owner    <= owner_d;
      grant    <= grant_d;
      busy     <= busy_d;
      tx_start <= start_d;
      tx_data  <= data_d;
      last_q   <= last_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stall   <= '0;
      timeout <= 1'b0;
    end else begin
      stall   <= stall_d;
      timeout <= timeout_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: packet queues per requester drive the DUT,
// a packet-level arbitration model predicts grant/start/data/ready every cycle.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1023;
`endif

  logic              clk = 1'b0;
  logic              nrst;
  logic [NREQ-1:0]   req_valid, req_last, req_ready, grant;
  logic [8*NREQ-1:0] req_data;
  logic              tx_start, tx_txe, busy, timeout;
  logic [7:0]        tx_data;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
    .tx_data(tx_data), .tx_txe(tx_txe), .grant(grant), .busy(busy),
    .timeout(timeout)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Each requester's pending bytes as {last, byte}.
  logic [8:0] q[NREQ][$];
  bit         en[NREQ];
  logic       txe_drv;

  // Reference: who owns the transmitter, who owned it last, and whether a start is in flight.
  int         m_own, m_last, m_stall;
  bit         m_iss, m_iss_last, m_start, m_to, hs;
  logic [7:0] m_data;

  function automatic void model_reset();
    m_own = -1; m_last = NREQ - 1; m_stall = 0;
    m_iss = 0; m_iss_last = 0; m_start = 0; m_to = 0; m_data = 8'h00; hs = 0;
  endfunction

  function automatic int next_owner();
    for (int k = 1; k <= NREQ; k++)
      if (req_valid[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
    return -1;
  endfunction

  function automatic void model_step();
    m_start = 0; m_to = 0;
    if (m_own < 0) begin
      m_stall = 0;
      if (|req_valid) m_own = next_owner();
    end else if (m_iss) begin
      m_iss = 0; m_stall = 0;
      if (m_iss_last) begin m_last = m_own; m_own = -1; end
    end else if (hs) begin
      m_start = 1; m_data = req_data[8*m_own +: 8];
      m_iss_last = req_last[m_own]; m_iss = 1; m_stall = 0;
    end else if (!req_valid[m_own]) begin
`ifdef UART_ARB_TIMEOUT_EN
      m_stall++;
      if (m_stall == TO) begin m_to = 1; m_last = m_own; m_own = -1; m_stall = 0; end
`endif
    end else begin
      m_stall = 0;
    end
  endfunction

  task automatic apply_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if (q[i].size() > 0) begin
        req_valid[i]      = en[i];
        req_data[8*i +: 8] = q[i][0][7:0];
        req_last[i]       = q[i][0][8];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i]       = 1'($urandom);
      end
    end
    tx_txe = txe_drv;
  endtask

  task automatic cycle();
    int own0 = m_own;
    bit hs0 = hs;
    logic [NREQ-1:0] exp_ready, exp_grant;
    model_step();
    @(posedge clk); #1;
    if (hs0) void'(q[own0].pop_front());
    exp_grant = '0;
    if (m_own >= 0) exp_grant[m_own] = 1'b1;
    chk("grant", grant, exp_grant);
    chk("busy", busy, m_own >= 0);
    chk("tx_start", tx_start, m_start);
    if (m_start) chk("tx_data", tx_data, m_data);
    chk("timeout", timeout, m_to);
    apply_inputs(); #1;
    exp_ready = '0;
    if (m_own >= 0 && !m_iss && txe_drv) exp_ready[m_own] = 1'b1;
    chk("req_ready", req_ready, exp_ready);
    hs = (m_own >= 0) && exp_ready[m_own] && req_valid[m_own];
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  task automatic do_reset();
    #2 nrst = 1'b0;
    model_reset();
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_timeout", timeout, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) nrst = 1'b1;
    apply_inputs();
    hs = 0;
  endtask

  task automatic push_pkt(input int r, input int len);
    for (int b = 0; b < len; b++) q[r].push_back({b == len - 1, 8'($urandom)});
  endtask

  initial begin
    nrst = 1'b0; txe_drv = 1'b1;
    for (int i = 0; i < NREQ; i++) en[i] = 1'b1;
    apply_inputs();
    do_reset();

    // three-byte packet 41,42,43 on requester 0
    q[0].push_back(9'h041); q[0].push_back(9'h042); q[0].push_back(9'h143);
    run(10);

    // requesters 0 and 2 single-byte packets
    q[0].push_back(9'h110); q[2].push_back(9'h120);
    run(10);

    // everyone busy with single-byte packets: rotation and wrap
    for (int i = 0; i < NREQ; i++) begin push_pkt(i, 1); push_pkt(i, 1); end
    run(24);

    // transmitter not ready while locked
    push_pkt(1, 2);
    txe_drv = 1'b0;
    run(22);
    txe_drv = 1'b1;
    run(8);

    // reset while a start is in flight; requester 0 must win afterwards
    push_pkt(0, 3); push_pkt(1, 2); push_pkt(3, 1);
    for (int c = 0; c < 20 && !m_iss; c++) cycle();
    chk("issue_seen", tx_start, 1);
    do_reset();
    run(20);

    // owner falls silent mid-packet while requester 0 waits
    q[3].push_back(9'h055); push_pkt(0, 1);
    run(20);
    q[3].push_back(9'h156);
    run(10);

    // randomized traffic with gated valids, txe stalls and occasional reset
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int r = $urandom_range(0, NREQ - 1);
        if (q[r].size() < 8) push_pkt(r, $urandom_range(1, 4));
      end
      for (int i = 0; i < NREQ; i++) en[i] = ($urandom_range(0, 7) != 0);
      txe_drv = ($urandom_range(0, 3) != 0);
      if (c % 750 == 749) do_reset();
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
